// File: rtl/cnn_pkg.sv
// Shared constants and FSM encodings for the MNIST CNN pipeline blocks.
// Pixel and class widths are common to fc_layer, comparator and sequencer.
package cnn_pkg;

  localparam int FRAME_PIXELS = 784;
  localparam int PIX_BIT      = 8;
  localparam int CLASS_BIT    = 4;

  localparam logic [CLASS_BIT-1:0] CLASS_TIMEOUT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STREAM,
    ST_WAIT
  } seq_state_e;

endpackage

// File: rtl/seq_addr_gen.sv
// Pixel RAM address generator: per-image base accumulator plus pixel counter.
// The base advances by one frame per image, so no multiplier is needed.
module seq_addr_gen #(
  parameter int FRAME_PIXELS = cnn_pkg::FRAME_PIXELS,
  parameter int ADDR_BIT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  input  logic                next_img,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic                last_pix
);

  localparam int PIX_W = $clog2(FRAME_PIXELS + 1);

  localparam logic [ADDR_BIT-1:0] FRAME_STEP =
    ADDR_BIT'(FRAME_PIXELS);
  localparam logic [PIX_W-1:0] PIX_LAST =
    PIX_W'(FRAME_PIXELS - 1);

  logic [ADDR_BIT-1:0] base_q, base_d;
  logic [PIX_W-1:0]    pix_q, pix_d;

  assign last_pix = (pix_q == PIX_LAST);
  assign mem_addr = base_q + ADDR_BIT'(pix_q);

  always_comb begin
    base_d = base_q;
    pix_d  = pix_q;
    if (clear) begin
      base_d = '0;
      pix_d  = '0;
    end else if (next_img) begin
      base_d = base_q + FRAME_STEP;
      pix_d  = '0;
    end else if (step) begin
      pix_d = last_pix ? '0 : pix_q + PIX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      pix_q  <= '0;
    end else begin
      base_q <= base_d;
      pix_q  <= pix_d;
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Batch sequencer: flushes, streams and collects one decision per image.
// Define SEQ_TIMEOUT_EN to add the per-image WAIT timeout and timeout_err.
module cnn_frame_sequencer #(
  parameter int FRAME_PIXELS = cnn_pkg::FRAME_PIXELS,
  parameter int PIX_BIT      = cnn_pkg::PIX_BIT,
  parameter int ADDR_BIT     = 16,
  parameter int IMG_BIT      = 8,
  parameter int CLASS_BIT    = cnn_pkg::CLASS_BIT,
  parameter int FLUSH_CYCLES = 2
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IMG_BIT-1:0]   num_images,
  output logic                 mem_rd_en,
  output logic [ADDR_BIT-1:0]  mem_addr,
  input  logic [PIX_BIT-1:0]   mem_rd_data,
  output logic [PIX_BIT-1:0]   pix_data,
  output logic                 pix_valid,
  output logic                 pipe_rst,
  input  logic                 dec_valid,
  input  logic [CLASS_BIT-1:0] dec_class,
  output logic                 result_valid,
  output logic [CLASS_BIT-1:0] result_class,
  output logic [IMG_BIT-1:0]   result_index,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  import cnn_pkg::*;

  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [FL_W-1:0] FLUSH_LAST =
    FL_W'(FLUSH_CYCLES - 1);

  seq_state_e state_q, state_d;

  logic [IMG_BIT-1:0]   num_q, num_d;
  logic [IMG_BIT-1:0]   img_q, img_d;
  logic [FL_W-1:0]      flush_q, flush_d;
  logic                 pv_q, pv_d;
  logic                 res_v_q, res_v_d;
  logic [CLASS_BIT-1:0] res_cls_q, res_cls_d;
  logic [IMG_BIT-1:0]   res_idx_q, res_idx_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tmo_err_q, tmo_err_d;

  logic start_ok;
  logic last_img;
  logic flush_end;
  logic last_pix;
  logic tmo_hit;
  logic fire;
  logic step;
  logic clear;
  logic next_img;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign last_img  = (img_q == num_q - IMG_BIT'(1));
  assign flush_end = (flush_q == FLUSH_LAST);

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] timer_q, timer_d;

  assign tmo_hit = (timer_q == TMO_LAST) && !dec_valid;

  always_comb begin
    timer_d = '0;
    if (state_q == ST_WAIT && !fire) begin
      timer_d = timer_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign fire = (state_q == ST_WAIT) && (dec_valid || tmo_hit);

  seq_addr_gen #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_BIT     (ADDR_BIT)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .step     (step),
    .next_img (next_img),
    .mem_addr (mem_addr),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && num_images != '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_end) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_pix) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fire) state_d = last_img ? ST_IDLE : ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == ST_STREAM);
    pipe_rst  = (state_q == ST_FLUSH);
    step      = (state_q == ST_STREAM);
    clear     = start_ok;
    next_img  = fire && !last_img;
  end

  always_comb begin
    num_d     = num_q;
    img_d     = img_q;
    flush_d   = '0;
    pv_d      = mem_rd_en;
    res_v_d   = fire;
    res_cls_d = res_cls_q;
    res_idx_d = res_idx_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    tmo_err_d = tmo_err_q;

    if (start_ok) begin
      num_d     = num_images;
      img_d     = '0;
      busy_d    = (num_images != '0);
      done_d    = (num_images == '0);
      tmo_err_d = 1'b0;
    end

    if (state_q == ST_FLUSH && !flush_end) begin
      flush_d = flush_q + FL_W'(1);
    end

    // Decoder wins if it answers on the very cycle the timer expires
    if (fire) begin
      res_cls_d = dec_valid ? dec_class : CLASS_TIMEOUT;
      res_idx_d = img_q;
      if (tmo_hit) tmo_err_d = 1'b1;
      if (last_img) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        img_d = img_q + IMG_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q     <= '0;
      img_q     <= '0;
      flush_q   <= '0;
      pv_q      <= 1'b0;
      res_v_q   <= 1'b0;
      res_cls_q <= '0;
      res_idx_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      num_q     <= num_d;
      img_q     <= img_d;
      flush_q   <= flush_d;
      pv_q      <= pv_d;
      res_v_q   <= res_v_d;
      res_cls_q <= res_cls_d;
      res_idx_q <= res_idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign pix_valid    = pv_q;
  assign pix_data     = pv_q ? mem_rd_data : '0;
  assign result_valid = res_v_q;
  assign result_class = res_cls_q;
  assign result_index = res_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef SEQ_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer with a 1-cycle pixel RAM model.
// Define SEQ_TIMEOUT_EN to also exercise the 16-cycle WAIT timeout.
module tb_cnn_frame_sequencer;

  localparam int FP = 784;

`ifdef SEQ_TIMEOUT_EN
  localparam int DLY = 5;
`else
  localparam int DLY = 299;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_images;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pipe_rst;
  logic        dec_valid;
  logic [3:0]  dec_class;
  logic        result_valid;
  logic [3:0]  result_class;
  logic [7:0]  result_index;
  logic        busy;
  logic        done;
  logic        timeout_err;

  logic clr_stats;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cnn_frame_sequencer #(
    .FLUSH_CYCLES (2)
`ifdef SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_images   (num_images),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pipe_rst     (pipe_rst),
    .dec_valid    (dec_valid),
    .dec_class    (dec_class),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_index (result_index),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  function automatic logic [7:0] pix_of(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pix_of(mem_addr);
  end

  // Monitor statistics, cleared by clr_stats
  int rd_cnt, addr_err, flush_err, ovl_err;
  int pix_err, pv_cnt;
  int pr_cyc, pr_bursts, pr_run, burst_err;
  int res_cnt, done_cnt, done_res, busy_seen, busy_done;
  logic [3:0] res_cls [8];
  logic [7:0] res_idx [8];
  logic        prev_rd = 1'b0;
  logic        prev_pr = 1'b0;
  logic        prev_rst = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (clr_stats) begin
      rd_cnt <= 0; addr_err <= 0; flush_err <= 0; ovl_err <= 0;
      pix_err <= 0; pv_cnt <= 0;
      pr_cyc <= 0; pr_bursts <= 0; pr_run <= 0; burst_err <= 0;
      res_cnt <= 0; done_cnt <= 0; done_res <= 0;
      busy_seen <= 0; busy_done <= 0;
    end else begin
      if (mem_rd_en) begin
        if (mem_addr != 16'(rd_cnt)) addr_err <= addr_err + 1;
        if (!prev_pr && !prev_rd) flush_err <= flush_err + 1;
        rd_cnt <= rd_cnt + 1;
      end
      if (mem_rd_en && pipe_rst) ovl_err <= ovl_err + 1;
      if (pix_valid !== (prev_rd && !prev_rst))
        pix_err <= pix_err + 1;
      else if (pix_valid && pix_data !== pix_of(prev_addr))
        pix_err <= pix_err + 1;
      else if (!pix_valid && pix_data !== 8'h00)
        pix_err <= pix_err + 1;
      if (pix_valid) pv_cnt <= pv_cnt + 1;
      if (pipe_rst) begin
        pr_run <= pr_run + 1;
        pr_cyc <= pr_cyc + 1;
        if (!prev_pr) pr_bursts <= pr_bursts + 1;
      end else begin
        if (prev_pr && pr_run != 2) burst_err <= burst_err + 1;
        pr_run <= 0;
      end
      if (result_valid) begin
        if (res_cnt < 8) begin
          res_cls[res_cnt] <= result_class;
          res_idx[res_cnt] <= result_index;
        end
        res_cnt <= res_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (result_valid) done_res <= done_res + 1;
      end
      if (busy) busy_seen <= busy_seen + 1;
      if (busy && done) busy_done <= busy_done + 1;
    end
    prev_rd   <= mem_rd_en;
    prev_pr   <= pipe_rst;
    prev_rst  <= rst;
    prev_addr <= mem_addr;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_test();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic go(input int n);
    start      = 1'b1;
    num_images = 8'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_reads(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (rd_cnt >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic decide(input int cls, input int dly);
    repeat (dly) tick();
    dec_valid = 1'b1;
    dec_class = 4'(cls);
    tick();
    dec_valid = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {mem_rd_en, mem_addr, pix_data, pix_valid, pipe_rst,
            result_valid, result_class, result_index,
            busy, done, timeout_err};
  endfunction

  task automatic chk_stats(input string t, input int rd,
                           input int bursts, input int res,
                           input int dn);
    chk({t, "_rd_cnt"}, rd_cnt, rd);
    chk({t, "_addr"}, addr_err, 0);
    chk({t, "_pix"}, pix_err, 0);
    chk({t, "_pv_cnt"}, pv_cnt, rd);
    chk({t, "_flush_first"}, flush_err, 0);
    chk({t, "_rd_pr_ovl"}, ovl_err, 0);
    chk({t, "_pr_bursts"}, pr_bursts, bursts);
    chk({t, "_pr_cyc"}, pr_cyc, 2 * bursts);
    chk({t, "_burst_len"}, burst_err, 0);
    chk({t, "_res_cnt"}, res_cnt, res);
    chk({t, "_done_cnt"}, done_cnt, dn);
    chk({t, "_busy_done"}, busy_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int lat;

    rst        = 1'b1;
    start      = 1'b0;
    num_images = '0;
    dec_valid  = 1'b0;
    dec_class  = '0;
    clr_stats  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outs", all_outs(), 64'h0);
    new_test();

    // 1: single image, decision after a long WAIT
    go(1);
    wait_reads(FP, ok);
    chk("t1_wait", ok, 1);
    decide(3, DLY);
    chk("t1_rv", result_valid, 1);
    chk("t1_cls", result_class, 3);
    chk("t1_idx", result_index, 0);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_tmo", timeout_err, 0);
    repeat (3) tick();
    chk("t1_rv_once", result_valid, 0);
    chk_stats("t1", FP, 1, 1, 1);
    chk("t1_done_res", done_res, 1);
    new_test();

    // 2: three images, contiguous addresses
    go(3);
    for (int k = 0; k < 3; k++) begin
      wait_reads(FP * (k + 1), ok);
      chk("t2_wait", ok, 1);
      decide(5 + 2 * k, k + 1);
      chk("t2_rv", result_valid, 1);
      chk("t2_cls", result_class, 5 + 2 * k);
      chk("t2_idx", result_index, k);
      chk("t2_done", done, (k == 2));
    end
    repeat (3) tick();
    chk_stats("t2", 3 * FP, 3, 3, 1);
    chk("t2_idx1", res_idx[1], 1);
    chk("t2_cls2", res_cls[2], 9);
    new_test();

    // 3: empty batch
    go(0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_done_pulse", done, 0);
    repeat (3) tick();
    chk("t3_busy_seen", busy_seen, 0);
    chk_stats("t3", 0, 0, 0, 1);
    new_test();

    // 4: stray decision and start while streaming
    go(1);
    wait_reads(100, ok);
    chk("t4_wait100", ok, 1);
    dec_valid  = 1'b1;
    dec_class  = 4'd7;
    start      = 1'b1;
    num_images = 8'd5;
    tick();
    dec_valid = 1'b0;
    start     = 1'b0;
    wait_reads(FP, ok);
    chk("t4_wait", ok, 1);
    chk("t4_no_res", res_cnt, 0);
    decide(2, 10);
    chk("t4_cls", result_class, 2);
    chk("t4_done", done, 1);
    repeat (5) tick();
    chk_stats("t4", FP, 1, 1, 1);
    new_test();

    // 5: reset mid-stream of image 1, then fresh start
    go(2);
    wait_reads(FP, ok);
    decide(1, 3);
    chk("t5_rv0", result_valid, 1);
    wait_reads(FP + 400, ok);
    chk("t5_wait400", ok, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_outs", all_outs(), 64'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_done", done_cnt, 0);
    chk("t5_res_cnt", res_cnt, 1);
    chk("t5_idle", busy, 0);
    new_test();
    go(1);
    wait_reads(FP, ok);
    chk("t5_wait_re", ok, 1);
    decide(4, 2);
    chk("t5_idx", result_index, 0);
    chk("t5_done", done, 1);
    repeat (3) tick();
    chk_stats("t5", FP, 1, 1, 1);
    new_test();

`ifdef SEQ_TIMEOUT_EN
    // 6: no decisions, both images time out
    go(2);
    for (int k = 0; k < 2; k++) begin
      wait_reads(FP * (k + 1), ok);
      chk("t6_wait", ok, 1);
      lat = 0;
      for (int i = 0; i < 100 && !result_valid; i++) begin
        tick();
        lat++;
      end
      chk("t6_lat", lat, 16);
      chk("t6_cls", result_class, 4'hF);
      chk("t6_idx", result_index, k);
      chk("t6_err", timeout_err, 1);
      chk("t6_done", done, (k == 1));
    end
    tick();
    go(0);
    chk("t6_err_clr", timeout_err, 0);
`else
    lat = 0;
    chk("t6_no_tmo", timeout_err, lat);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
